// File: rtl/mem_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_buffer_pkg
// Description : Shared constants and types for the MIPS16 MEM-stage store
//               buffer.
//               - SB_DEPTH            : number of buffered stores
//               - DATA_MEM_ADDR_WIDTH : significant data_mem address bits;
//                                       data_mem aliases above this width
//               - SB_DATA_W           : data word width
//               - SB_PORT_ADDR_W      : width of the pipeline address buses
//               - dm_sel_e            : data_mem port mux select
// Revision    : 1.0 - initial release
// ============================================================================
package mem_store_buffer_pkg;

    localparam int SB_DEPTH            = 4;
    localparam int DATA_MEM_ADDR_WIDTH = 8;
    localparam int SB_DATA_W           = 16;
    localparam int SB_PORT_ADDR_W      = 16;

    // Owner of the data_mem port in the current cycle
    typedef enum logic [1:0] {
        DM_IDLE  = 2'd0,
        DM_LOAD  = 2'd1,
        DM_DRAIN = 2'd2
    } dm_sel_e;

endpackage : mem_store_buffer_pkg
`default_nettype wire

// File: rtl/mem_store_buffer_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : sb_fwd_match
// Description : Combinational youngest-match select over the store buffer.
//               Entries are walked from the oldest (i_rd_ptr) toward the
//               youngest; a later match overrides an earlier one, so the
//               youngest matching valid entry wins.
// Ports       : i_valid   - per-entry valid bits
//               i_addr    - per-entry stored address (ADDR_W bits)
//               i_data    - per-entry stored data
//               i_rd_ptr  - index of the oldest entry
//               i_ld_addr - load address (ADDR_W bits)
//               o_hit     - at least one valid entry matches
//               o_data    - data of the youngest matching entry ('0 on miss)
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic [DEPTH-1:0]                     i_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0]         i_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]         i_data,
    input  logic [$clog2(DEPTH)-1:0]             i_rd_ptr,
    input  logic [ADDR_W-1:0]                    i_ld_addr,
    output logic                                 o_hit,
    output logic [DATA_W-1:0]                    o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        // Age 0 is the oldest entry; the index wraps naturally at PTR_W bits
        for (int a = 0; a < DEPTH; a++) begin
            w_idx = i_rd_ptr + PTR_W'(a);
            if (i_valid[w_idx] && (i_addr[w_idx] == i_ld_addr)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule : sb_fwd_match
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_buffer
// Description : Write-posting buffer between EX/MEM and data_mem.
//               Stores are queued in a DEPTH-entry FIFO and drained to
//               data_mem on cycles without a load; loads own the data_mem
//               port and see buffered stores via youngest-match forwarding.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               st_valid/addr/data  - store request
//               ld_valid/addr       - load request
//               ld_data             - load result (combinational)
//               stall               - store not accepted this cycle
//               drain_all           - drain on every non-load cycle
//               empty               - no entries buffered
//               dm_addr/wdata/we    - data_mem access port
//               dm_rdata            - data_mem combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = DATA_MEM_ADDR_WIDTH,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        st_valid,
    input  logic [SB_PORT_ADDR_W-1:0]   st_addr,
    input  logic [DATA_W-1:0]           st_data,
    input  logic                        ld_valid,
    input  logic [SB_PORT_ADDR_W-1:0]   ld_addr,
    output logic [DATA_W-1:0]           ld_data,
    output logic                        stall,
    input  logic                        drain_all,
    output logic                        empty,
    output logic [SB_PORT_ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]           dm_wdata,
    output logic                        dm_we,
    input  logic [DATA_W-1:0]           dm_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]               r_wr_ptr;
    logic [PTR_W-1:0]               r_rd_ptr;
    logic [CNT_W-1:0]               r_count;
    logic [DEPTH-1:0]               r_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]   r_addr;
    logic [DEPTH-1:0][DATA_W-1:0]   r_data;

    logic                           w_full;
    logic                           w_nonempty;
    logic                           w_drain;
    logic                           w_accept;
    logic                           w_hit;
    logic [DATA_W-1:0]              w_fwd_data;
    dm_sel_e                        w_dm_sel;
    logic                           w_unused_st_hi;

    // Upper store-address bits alias away in data_mem
    assign w_unused_st_hi = ^st_addr[SB_PORT_ADDR_W-1:ADDR_W];

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_nonempty = (r_count != '0);

    // A load always owns the port. Otherwise drain when there is no store
    // competing, when the buffer is full (making room for the held store),
    // or when a full flush is requested.
    assign w_drain  = !ld_valid && w_nonempty && (!st_valid || w_full || drain_all);
    assign w_accept = st_valid && !ld_valid && !w_full;

    // A store colliding with a load is refused, as is one meeting a full buffer
    assign stall = st_valid && (ld_valid || w_full);
    assign empty = !w_nonempty;

    // ------------------------------------------------------------------
    // FIFO control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            // wr_ptr never equals rd_ptr while both happen (count < DEPTH, > 0)
            if (w_accept) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            case ({w_accept, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage: qualified by r_valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr[r_wr_ptr] <= st_addr[ADDR_W-1:0];
            r_data[r_wr_ptr] <= st_data;
        end
    end

    // ------------------------------------------------------------------
    // Load forwarding
    // ------------------------------------------------------------------
    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .i_valid   (r_valid),
        .i_addr    (r_addr),
        .i_data    (r_data),
        .i_rd_ptr  (r_rd_ptr),
        .i_ld_addr (ld_addr[ADDR_W-1:0]),
        .o_hit     (w_hit),
        .o_data    (w_fwd_data)
    );

    assign ld_data = w_hit ? w_fwd_data : dm_rdata;

    // ------------------------------------------------------------------
    // data_mem port mux
    // ------------------------------------------------------------------
    always_comb begin
        w_dm_sel = DM_IDLE;
        if (ld_valid) begin
            w_dm_sel = DM_LOAD;
        end else if (w_drain) begin
            w_dm_sel = DM_DRAIN;
        end
    end

    always_comb begin
        dm_addr  = '0;
        dm_wdata = '0;
        dm_we    = 1'b0;
        case (w_dm_sel)
            DM_LOAD: begin
                dm_addr = ld_addr;
            end
            DM_DRAIN: begin
                dm_addr[ADDR_W-1:0] = r_addr[r_rd_ptr];
                dm_wdata            = r_data[r_rd_ptr];
                dm_we               = 1'b1;
            end
            default: begin
                dm_addr  = '0;
                dm_wdata = '0;
                dm_we    = 1'b0;
            end
        endcase
    end

endmodule : mem_store_buffer
`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_store_buffer
// Description : Self-checking bench for mem_store_buffer with a behavioural
//               data_mem and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_store_buffer;
    import mem_store_buffer_pkg::*;

    localparam int AW    = DATA_MEM_ADDR_WIDTH;
    localparam int DW    = SB_DATA_W;
    localparam int DEPTH = SB_DEPTH;
    localparam int NWORD = 1 << AW;

    logic          clk;
    logic          rst;
    logic          st_valid;
    logic [15:0]   st_addr;
    logic [DW-1:0] st_data;
    logic          ld_valid;
    logic [15:0]   ld_addr;
    logic [DW-1:0] ld_data;
    logic          stall;
    logic          drain_all;
    logic          empty;
    logic [15:0]   dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_we;
    logic [DW-1:0] dm_rdata;

    mem_store_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .stall     (stall),
        .drain_all (drain_all),
        .empty     (empty),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_we     (dm_we),
        .dm_rdata  (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural data_mem: combinational read, write at posedge
    // ------------------------------------------------------------------
    logic [DW-1:0] ram [NWORD];
    logic          init;

    function automatic logic [DW-1:0] init_val(int i);
        return 16'hC000 | 16'(i);
    endfunction

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < NWORD; i++) ram[i] <= init_val(i);
        end else if (dm_we) begin
            ram[dm_addr[AW-1:0]] <= dm_wdata;
        end
    end
    assign dm_rdata = ram[dm_addr[AW-1:0]];

    // ------------------------------------------------------------------
    // Reference model: a queue of pending stores and an image of memory
    // ------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] mref [NWORD];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs sampled just before the active edge of the last cycle
    logic          s_stall, s_we, s_empty;
    logic [15:0]   s_addr;
    logic [DW-1:0] s_wdata, s_ld;

    // One clock cycle: drive 1 ns after negedge, check 1 ns before posedge,
    // then advance the model as the posedge will.
    task automatic cyc(input bit st, input logic [15:0] sa, input logic [15:0] sd,
                       input bit ld, input logic [15:0] la, input bit da);
        int            n;
        bit            e_stall, e_drain, e_acc;
        logic [15:0]   e_addr;
        logic [DW-1:0] e_ld;
        @(negedge clk);
        #1;
        st_valid  = st;
        st_addr   = sa;
        st_data   = sd;
        ld_valid  = ld;
        ld_addr   = la;
        drain_all = da;
        #3;
        s_stall = stall;  s_we = dm_we;   s_empty = empty;
        s_addr  = dm_addr; s_wdata = dm_wdata; s_ld = ld_data;

        n       = mq.size();
        e_stall = st && (ld || n == DEPTH);
        e_drain = !ld && n > 0 && (!st || n == DEPTH || da);
        e_acc   = st && !ld && n < DEPTH;
        e_addr  = ld ? la : (e_drain ? 16'(mq[0].a) : 16'h0);

        chk("m_stall", 16'(s_stall), 16'(e_stall));
        chk("m_we",    16'(s_we),    16'(e_drain));
        chk("m_empty", 16'(s_empty), 16'(n == 0));
        chk("m_addr",  s_addr, e_addr);
        if (e_drain) chk("m_wdata", s_wdata, mq[0].d);
        else if (!ld) chk("m_wdata", s_wdata, 16'h0);
        if (ld) begin
            e_ld = mref[la[AW-1:0]];
            for (int i = 0; i < n; i++)
                if (mq[i].a == la[AW-1:0]) e_ld = mq[i].d;
            chk("m_ld_data", s_ld, e_ld);
        end

        if (e_drain) begin
            mref[mq[0].a] = mq[0].d;
            void'(mq.pop_front());
        end
        if (e_acc) mq.push_back('{a: sa[AW-1:0], d: sd});
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 16'h0, 16'h0, 0, 16'h0, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          st;
        logic [15:0] sa, sd;
        bit          ld;
        logic [15:0] la;
        bit          e_stall, e_we;
        logic [15:0] e_addr, e_wdata;
        bit          chk_ld;
        logic [15:0] e_ld;
        bit          e_empty;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [NV];

    function automatic vec_t mk(bit st, logic [15:0] sa, logic [15:0] sd, bit ld, logic [15:0] la,
                                bit es, bit ew, logic [15:0] eaddr, logic [15:0] ewd,
                                bit cl, logic [15:0] eld, bit eem);
        vec_t v;
        v.st = st; v.sa = sa; v.sd = sd; v.ld = ld; v.la = la;
        v.e_stall = es; v.e_we = ew; v.e_addr = eaddr; v.e_wdata = ewd;
        v.chk_ld = cl; v.e_ld = eld; v.e_empty = eem;
        return v;
    endfunction

    initial begin
        // idle drain
        vt[0]  = mk(1, 16'h0005, 16'h1234, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    1);
        vt[1]  = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 1, 16'h0005, 16'h1234, 0, 16'h0,    0);
        vt[2]  = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    1);
        // forwarding, youngest wins; miss reads memory
        vt[3]  = mk(1, 16'h0009, 16'hAAAA, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    1);
        vt[4]  = mk(1, 16'h0009, 16'hBBBB, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    0);
        vt[5]  = mk(0, 16'h0,    16'h0,    1, 16'h9, 0, 0, 16'h0009, 16'h0000, 1, 16'hBBBB, 0);
        vt[6]  = mk(0, 16'h0,    16'h0,    1, 16'h3, 0, 0, 16'h0003, 16'h0000, 1, 16'hC003, 0);
        vt[7]  = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 1, 16'h0009, 16'hAAAA, 0, 16'h0,    0);
        vt[8]  = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 1, 16'h0009, 16'hBBBB, 0, 16'h0,    0);
        vt[9]  = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    1);
        // full buffer: one stall cycle while the head drains
        vt[10] = mk(1, 16'h0001, 16'h1001, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    1);
        vt[11] = mk(1, 16'h0002, 16'h1002, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    0);
        vt[12] = mk(1, 16'h0003, 16'h1003, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    0);
        vt[13] = mk(1, 16'h0004, 16'h1004, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    0);
        vt[14] = mk(1, 16'h0007, 16'h7777, 0, 16'h0, 1, 1, 16'h0001, 16'h1001, 0, 16'h0,    0);
        vt[15] = mk(1, 16'h0007, 16'h7777, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    0);
        vt[16] = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 1, 16'h0002, 16'h1002, 0, 16'h0,    0);
        vt[17] = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 1, 16'h0003, 16'h1003, 0, 16'h0,    0);
        vt[18] = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 1, 16'h0004, 16'h1004, 0, 16'h0,    0);
        vt[19] = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 1, 16'h0007, 16'h7777, 0, 16'h0,    0);
        vt[20] = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    1);
        // aliasing above ADDR_W
        vt[21] = mk(1, 16'h0106, 16'h0C0C, 0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    1);
        vt[22] = mk(0, 16'h0,    16'h0,    1, 16'h6, 0, 0, 16'h0006, 16'h0000, 1, 16'h0C0C, 0);
        vt[23] = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 1, 16'h0006, 16'h0C0C, 0, 16'h0,    0);
        vt[24] = mk(0, 16'h0,    16'h0,    0, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0,    1);
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int nerr;
        rst = 1'b1; init = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; drain_all = 1'b0;
        for (int i = 0; i < NWORD; i++) mref[i] = init_val(i);

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_empty", 16'(empty), 16'h1);
        chk("rst_we",    16'(dm_we), 16'h0);
        chk("rst_addr",  dm_addr,    16'h0);
        chk("rst_wdata", dm_wdata,   16'h0);
        rst = 1'b0; init = 1'b0;

        // Directed table
        for (int v = 0; v < NV; v++) begin
            cyc(vt[v].st, vt[v].sa, vt[v].sd, vt[v].ld, vt[v].la, 0);
            chk($sformatf("v%0d_stall", v), 16'(s_stall), 16'(vt[v].e_stall));
            chk($sformatf("v%0d_we", v),    16'(s_we),    16'(vt[v].e_we));
            chk($sformatf("v%0d_addr", v),  s_addr,       vt[v].e_addr);
            chk($sformatf("v%0d_empty", v), 16'(s_empty), 16'(vt[v].e_empty));
            if (vt[v].e_we) chk($sformatf("v%0d_wdata", v), s_wdata, vt[v].e_wdata);
            if (vt[v].chk_ld) chk($sformatf("v%0d_ld_data", v), s_ld, vt[v].e_ld);
        end
        @(negedge clk);
        chk("ram5", ram[5], 16'h1234);
        chk("ram9", ram[9], 16'hBBBB);
        for (int i = 1; i <= 4; i++) chk($sformatf("ram%0d", i), ram[i], 16'h1000 | 16'(i));
        chk("ram7", ram[7], 16'h7777);
        chk("ram6", ram[6], 16'h0C0C);

        // drain_all with a store every cycle keeps occupancy at three
        for (int i = 0; i < 3; i++) cyc(1, 16'h10 + 16'(i), 16'hD000 + 16'(i), 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 16'h13 + 16'(i), 16'hD003 + 16'(i), 0, 16'h0, 1);
            chk("da_we", 16'(s_we), 16'h1);
            chk("da_stall", 16'(s_stall), 16'h0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 16'h0, 16'h0, 0, 16'h0, 0);
            chk("da_tail_we", 16'(s_we), 16'h1);
            chk("da_tail_empty", 16'(s_empty), 16'h0);
        end
        cyc(0, 16'h0, 16'h0, 0, 16'h0, 0);
        chk("da_empty", 16'(s_empty), 16'h1);

        // Reset in the middle of filling discards two pending stores
        cyc(1, 16'h20, 16'hE020, 0, 16'h0, 0);
        cyc(1, 16'h21, 16'hE021, 0, 16'h0, 0);
        @(negedge clk);
        #1;
        st_valid = 1'b0; ld_valid = 1'b0; drain_all = 1'b0;
        chk("pre_rst_empty", 16'(empty), 16'h0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_empty", 16'(empty), 16'h1);
        chk("mid_rst_we", 16'(dm_we), 16'h0);
        mq.delete();
        @(negedge clk);
        #1 rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            bit st, ld, da;
            r  = int'($urandom_range(0, 9));
            st = (r < 5) || (r == 9);
            ld = (r >= 5 && r < 8) || (r == 9);
            da = ($urandom_range(0, 3) == 0);
            cyc(st, {8'($urandom), 8'($urandom_range(0, 7))}, 16'($urandom),
                ld, {8'($urandom), 8'($urandom_range(0, 7))}, da);
        end
        idle(DEPTH + 2);
        @(negedge clk);
        nerr = 0;
        for (int i = 0; i < NWORD; i++) if (ram[i] !== mref[i]) nerr++;
        chk("ram_image_mismatches", 16'(nerr), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_store_buffer
`default_nettype wire
